// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - seven-segment font table, segment bit positions and polarity helper
package seg7_pkg;

  // Bit positions inside the 7-bit pattern {g,f,e,d,c,b,a}
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Active-high hex font, entry [n] lights the glyph for nibble n (0-9, A, b, C, d, E, F)
  localparam logic [15:0][6:0] SEG7_FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [7:0] act_level(input logic [7:0] v, input logic act_low);
    return act_low ? ~v : v;
  endfunction

endpackage

// File: rtl/seg7_hex_encoder.sv
// rtl/seg7_hex_encoder.sv - combinational nibble to active-high seven-segment pattern
module seg7_hex_encoder (
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);
  import seg7_pkg::*;

  logic [6:0] glyph;

  assign glyph   = SEG7_FONT[nibble];
  assign pattern = {glyph[SEG_G], glyph[SEG_F], glyph[SEG_E], glyph[SEG_D],
                    glyph[SEG_C], glyph[SEG_B], glyph[SEG_A]};

endmodule

// File: rtl/seg7_mux_display.sv
// rtl/seg7_mux_display.sv - N-digit multiplexed seven-segment driver with
// double-buffered load, leading-zero blanking, digit mask, PWM dimming and ghost blanking
module seg7_mux_display #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 16,
  parameter int BRIGHT_W    = 4,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit AN_ACT_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  input  logic [BRIGHT_W-1:0]     brightness,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    seg_dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);
  import seg7_pkg::*;

  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0] SEG_IDLE = SEG_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] AN_IDLE = AN_ACT_LOW ? '1 : '0;

  logic [PRE_W-1:0]        prescaler;
  logic [IDX_W-1:0]        idx;
  logic [BRIGHT_W-1:0]     pwm_cnt;
  logic [4*NUM_DIGITS-1:0] pending_value, shadow_value;
  logic [NUM_DIGITS-1:0]   pending_dp, shadow_dp;
  logic                    load_pending;
  logic                    slot_end, frame_end;

  assign slot_end  = (prescaler == PRE_W'(REFRESH_DIV - 1));
  assign frame_end = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescaler  <= '0;
      idx        <= '0;
      pwm_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      pwm_cnt    <= pwm_cnt + 1'b1;
      frame_done <= frame_end;
      if (slot_end) begin
        prescaler <= '0;
        idx       <= frame_end ? '0 : idx + 1'b1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

  // Shadow only changes on the frame wrap, so a frame never mixes two words.
  // A load coinciding with the wrap lands in pending and waits a full frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_value <= '0;
      pending_dp    <= '0;
      shadow_value  <= '0;
      shadow_dp     <= '0;
      load_pending  <= 1'b0;
    end else begin
      if (frame_end && load_pending) begin
        shadow_value <= pending_value;
        shadow_dp    <= pending_dp;
      end
      if (load) begin
        pending_value <= value;
        pending_dp    <= dp;
        load_pending  <= 1'b1;
      end else if (frame_end) begin
        load_pending <= 1'b0;
      end
    end
  end

  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  upper_zero;

  always_comb begin
    lz_blank   = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero  = upper_zero & (shadow_value[4*i +: 4] == 4'h0);
      lz_blank[i] = blank_lz & (i != 0) & upper_zero;
    end
  end

  logic [3:0]            cur_nib;
  logic                  cur_dp, cur_en, cur_lz;
  logic [NUM_DIGITS-1:0] an_onehot;

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_en    = 1'b0;
    cur_lz    = 1'b0;
    an_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib      = shadow_value[4*i +: 4];
        cur_dp       = shadow_dp[i];
        cur_en       = digit_en[i];
        cur_lz       = lz_blank[i];
        an_onehot[i] = 1'b1;
      end
    end
  end

  logic [6:0] font_pat;
  logic       lit;
  logic [7:0] seg_lvl;

  seg7_hex_encoder u_enc (
    .nibble  (cur_nib),
    .pattern (font_pat)
  );

  assign lit     = cur_en & ~cur_lz & (pwm_cnt < brightness) & (prescaler >= PRE_W'(BLANK_CYC));
  assign seg_lvl = act_level({lit & cur_dp, lit ? font_pat : 7'h00}, SEG_ACT_LOW);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {seg_dp, seg} <= SEG_IDLE;
      an            <= AN_IDLE;
    end else begin
      {seg_dp, seg} <= seg_lvl;
      an            <= lit ? (AN_ACT_LOW ? ~an_onehot : an_onehot) : AN_IDLE;
    end
  end

endmodule
